// File: rtl/regfile_mp_pkg.sv
// Shared constants for the multi-port register file.
// Holds the default geometry and the byte-lane count helper.
package regfile_mp_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NREAD_DEF  = 2;

    function automatic int lanes(input int data_w);
        return data_w / 8;
    endfunction
endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read ports, two byte-masked write ports and the busy scoreboard set.
// The master drives addresses and writes. The slave returns read data and busy flags.
interface regfile_mp_if #(
    parameter int DATA_W = regfile_mp_pkg::DATA_W_DEF,
    parameter int ADDR_W = regfile_mp_pkg::ADDR_W_DEF,
    parameter int NREAD  = regfile_mp_pkg::NREAD_DEF
);
    import regfile_mp_pkg::*;
    localparam int NLANE = lanes(DATA_W);

    logic [NREAD*ADDR_W-1:0] ra;
    logic [NREAD*DATA_W-1:0] rd;
    logic [NREAD-1:0]        rd_busy;
    logic                    we0, we1;
    logic [ADDR_W-1:0]       wa0, wa1;
    logic [DATA_W-1:0]       wd0, wd1;
    logic [NLANE-1:0]        wbe0, wbe1;
    logic                    busy_set;
    logic [ADDR_W-1:0]       busy_addr;

    modport master (
        output ra, we0, we1, wa0, wa1, wd0, wd1, wbe0, wbe1, busy_set, busy_addr,
        input  rd, rd_busy
    );
    modport slave (
        input  ra, we0, we1, wa0, wa1, wd0, wd1, wbe0, wbe1, busy_set, busy_addr,
        output rd, rd_busy
    );
endinterface

// File: rtl/regfile_rdport.sv
// One combinational read port: it forwards same-cycle writes lane by lane (port 1 over port 0),
// forces register 0 to zero and reports a pending-write flag.
module regfile_rdport #(
    parameter int DATA_W = regfile_mp_pkg::DATA_W_DEF,
    parameter int ADDR_W = regfile_mp_pkg::ADDR_W_DEF
) (
    input  logic                               rst,
    input  logic [ADDR_W-1:0]                  ra_i,
    input  logic [2**ADDR_W-1:0][DATA_W-1:0]   mem_i,
    input  logic [2**ADDR_W-1:0]               busy_i,
    input  logic                               we0_i,
    input  logic [ADDR_W-1:0]                  wa0_i,
    input  logic [DATA_W-1:0]                  wd0_i,
    input  logic [DATA_W/8-1:0]                wbe0_i,
    input  logic                               we1_i,
    input  logic [ADDR_W-1:0]                  wa1_i,
    input  logic [DATA_W-1:0]                  wd1_i,
    input  logic [DATA_W/8-1:0]                wbe1_i,
    output logic [DATA_W-1:0]                  rd_o,
    output logic                               rd_busy_o
);
    import regfile_mp_pkg::*;
    localparam int NLANE = lanes(DATA_W);

    logic hit0, hit1, clr, live;

    assign hit0 = we0_i && (wa0_i == ra_i);
    assign hit1 = we1_i && (wa1_i == ra_i);
    assign clr  = (hit0 && |wbe0_i) || (hit1 && |wbe1_i);
    // Register 0 and reset both read as zero, including any bypassed data.
    assign live = !rst && (ra_i != '0);

    always_comb begin
        rd_o = '0;
        if (live) begin
            for (int k = 0; k < NLANE; k++) begin
                if (hit1 && wbe1_i[k])
                    rd_o[k*8 +: 8] = wd1_i[k*8 +: 8];
                else if (hit0 && wbe0_i[k])
                    rd_o[k*8 +: 8] = wd0_i[k*8 +: 8];
                else
                    rd_o[k*8 +: 8] = mem_i[ra_i][k*8 +: 8];
            end
        end
    end

    assign rd_busy_o = live && busy_i[ra_i] && !clr;
endmodule

// File: rtl/regfile_mp.sv
// Flop-based register file with NREAD bypassing read ports, two byte-masked write ports
// and a per-register pending-write scoreboard. Reset clears everything asynchronously.
module regfile_mp #(
    parameter int DATA_W = regfile_mp_pkg::DATA_W_DEF,
    parameter int ADDR_W = regfile_mp_pkg::ADDR_W_DEF,
    parameter int NREAD  = regfile_mp_pkg::NREAD_DEF
) (
    input logic         clk,
    input logic         rst,
    regfile_mp_if.slave bus
);
    import regfile_mp_pkg::*;
    localparam int NLANE = lanes(DATA_W);
    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
    logic [DEPTH-1:0]             busy_q, busy_d;
    logic [NREAD-1:0][DATA_W-1:0] rd_w;
    logic [NREAD-1:0]             rd_busy_w;

    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        for (int r = 1; r < DEPTH; r++) begin
            // Port 1 owns every lane it enables; port 0 fills the rest.
            for (int k = 0; k < NLANE; k++) begin
                if (bus.we1 && bus.wa1 == ADDR_W'(r) && bus.wbe1[k])
                    mem_d[r][k*8 +: 8] = bus.wd1[k*8 +: 8];
                else if (bus.we0 && bus.wa0 == ADDR_W'(r) && bus.wbe0[k])
                    mem_d[r][k*8 +: 8] = bus.wd0[k*8 +: 8];
            end
            if ((bus.we0 && bus.wa0 == ADDR_W'(r) && |bus.wbe0) ||
                (bus.we1 && bus.wa1 == ADDR_W'(r) && |bus.wbe1))
                busy_d[r] = 1'b0;
            if (bus.busy_set && bus.busy_addr == ADDR_W'(r))
                busy_d[r] = 1'b1;
        end
        mem_d[0]  = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q  <= '0;
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    for (genvar g = 0; g < NREAD; g++) begin : g_rd
        regfile_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rdport (
            .rst       (rst),
            .ra_i      (bus.ra[g*ADDR_W +: ADDR_W]),
            .mem_i     (mem_q),
            .busy_i    (busy_q),
            .we0_i     (bus.we0),
            .wa0_i     (bus.wa0),
            .wd0_i     (bus.wd0),
            .wbe0_i    (bus.wbe0),
            .we1_i     (bus.we1),
            .wa1_i     (bus.wa1),
            .wd1_i     (bus.wd1),
            .wbe1_i    (bus.wbe1),
            .rd_o      (rd_w[g]),
            .rd_busy_o (rd_busy_w[g])
        );
    end

    assign bus.rd      = rd_w;
    assign bus.rd_busy = rd_busy_w;
endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them whenever a check strobe is raised.
module tb_regfile_mp;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    typedef struct {
        logic [8*16-1:0] name;
        int              port;
        logic [DW-1:0]   rd;
        logic            bsy;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic chk_vld = 1'b0;
    int   compared = 0;
    int   mismatched = 0;
    exp_t q[$];

    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR)) bus ();

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (chk_vld) begin
            while (q.size() > 0) begin
                exp_t e;
                logic [DW-1:0] got_d;
                logic          got_b;
                e     = q.pop_front();
                got_d = bus.rd[e.port*DW +: DW];
                got_b = bus.rd_busy[e.port];
                compared++;
                if (got_d !== e.rd) begin
                    mismatched++;
                    $display("FAIL %0s port%0d rd: got %h want %h", e.name, e.port, got_d, e.rd);
                end
                compared++;
                if (got_b !== e.bsy) begin
                    mismatched++;
                    $display("FAIL %0s port%0d rd_busy: got %b want %b", e.name, e.port, got_b, e.bsy);
                end
            end
        end
    end

    task automatic idle();
        bus.we0 = 1'b0; bus.wa0 = '0; bus.wd0 = '0; bus.wbe0 = '0;
        bus.we1 = 1'b0; bus.wa1 = '0; bus.wd1 = '0; bus.wbe1 = '0;
        bus.busy_set = 1'b0; bus.busy_addr = '0;
    endtask

    task automatic rdaddr(input int a0, input int a1);
        bus.ra = {AW'(a1), AW'(a0)};
    endtask

    task automatic push(input logic [8*16-1:0] nm, input int port, input logic [DW-1:0] d, input logic b);
        exp_t e;
        e.name = nm; e.port = port; e.rd = d; e.bsy = b;
        q.push_back(e);
    endtask

    // Raise the strobe for the monitor, then step to just after the next rising edge.
    task automatic sample();
        chk_vld = 1'b1;
        @(negedge clk);
        #1 chk_vld = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rdaddr(4, 4);
        @(posedge clk);
        #1;
        // Reset held: a write and busy_set are issued but must be invisible and discarded.
        bus.we0 = 1'b1; bus.wa0 = 5'd4; bus.wd0 = 32'hCAFEF00D; bus.wbe0 = 4'hF;
        bus.busy_set = 1'b1; bus.busy_addr = 5'd4;
        push("rst_bypass", 0, 32'h0, 1'b0);
        sample();
        rst = 1'b0;
        idle();
        push("rst_discard", 0, 32'h0, 1'b0);
        sample();

        for (int a = 0; a < 32; a++) begin
            rdaddr(a, a ^ 5);
            push("init_zero", 0, 32'h0, 1'b0);
            push("init_zero", 1, 32'h0, 1'b0);
            sample();
        end

        // Byte-masked overwrite of r3 across two cycles.
        bus.we0 = 1'b1; bus.wa0 = 5'd3; bus.wd0 = 32'hAABBCCDD; bus.wbe0 = 4'hF;
        rdaddr(3, 0);
        push("r3_full_byp", 0, 32'hAABBCCDD, 1'b0);
        push("r0_read", 1, 32'h0, 1'b0);
        sample();
        idle();
        bus.we1 = 1'b1; bus.wa1 = 5'd3; bus.wd1 = 32'h11223344; bus.wbe1 = 4'b0101;
        rdaddr(3, 3);
        push("r3_mask_byp", 0, 32'hAA22CC44, 1'b0);
        push("r3_mask_byp", 1, 32'hAA22CC44, 1'b0);
        sample();
        idle();
        push("r3_stored", 0, 32'hAA22CC44, 1'b0);
        sample();

        // Same-cycle collision on r7.
        bus.we0 = 1'b1; bus.wa0 = 5'd7; bus.wd0 = 32'h01010101; bus.wbe0 = 4'hF;
        bus.we1 = 1'b1; bus.wa1 = 5'd7; bus.wd1 = 32'hFFFFFFFF; bus.wbe1 = 4'b0011;
        rdaddr(7, 3);
        push("r7_coll_byp", 0, 32'h0101FFFF, 1'b0);
        push("r3_untouched", 1, 32'hAA22CC44, 1'b0);
        sample();
        idle();
        rdaddr(3, 7);
        push("r7_coll_st", 1, 32'h0101FFFF, 1'b0);
        sample();

        // Scoreboard on r5.
        bus.busy_set = 1'b1; bus.busy_addr = 5'd5;
        rdaddr(5, 5);
        push("r5_set_cyc", 0, 32'h0, 1'b0);
        sample();
        idle();
        push("r5_busy", 0, 32'h0, 1'b1);
        push("r5_busy", 1, 32'h0, 1'b1);
        sample();
        bus.we0 = 1'b1; bus.wa0 = 5'd5; bus.wd0 = 32'hFFFFFFAB; bus.wbe0 = 4'b0001;
        push("r5_clr_cyc", 0, 32'h000000AB, 1'b0);
        sample();
        idle();
        push("r5_cleared", 0, 32'h000000AB, 1'b0);
        sample();
        bus.we1 = 1'b1; bus.wa1 = 5'd5; bus.wd1 = 32'h000000CD; bus.wbe1 = 4'b0001;
        bus.busy_set = 1'b1; bus.busy_addr = 5'd5;
        push("r5_setclr_cyc", 1, 32'h000000CD, 1'b0);
        sample();
        idle();
        push("r5_set_wins", 1, 32'h000000CD, 1'b1);
        sample();
        bus.we0 = 1'b1; bus.wa0 = 5'd5; bus.wd0 = 32'hFFFFFFFF; bus.wbe0 = 4'b0000;
        push("r5_wbe0_cyc", 0, 32'h000000CD, 1'b1);
        sample();
        idle();
        push("r5_wbe0_after", 0, 32'h000000CD, 1'b1);
        sample();

        // Register 0 stays zero and never busy.
        bus.we0 = 1'b1; bus.wa0 = 5'd0; bus.wd0 = 32'hDEADBEEF; bus.wbe0 = 4'hF;
        bus.we1 = 1'b1; bus.wa1 = 5'd0; bus.wd1 = 32'hDEADBEEF; bus.wbe1 = 4'hF;
        bus.busy_set = 1'b1; bus.busy_addr = 5'd0;
        rdaddr(0, 0);
        push("r0_wr_cyc", 0, 32'h0, 1'b0);
        push("r0_wr_cyc", 1, 32'h0, 1'b0);
        sample();
        idle();
        push("r0_after", 0, 32'h0, 1'b0);
        sample();

        // r9 written and marked busy, then reset asserted between edges.
        bus.we1 = 1'b1; bus.wa1 = 5'd9; bus.wd1 = 32'h12345678; bus.wbe1 = 4'hF;
        bus.busy_set = 1'b1; bus.busy_addr = 5'd9;
        rdaddr(9, 9);
        push("r9_wr_cyc", 0, 32'h12345678, 1'b0);
        sample();
        idle();
        push("r9_busy", 0, 32'h12345678, 1'b1);
        push("r9_busy", 1, 32'h12345678, 1'b1);
        sample();
        #1 rst = 1'b1;
        bus.we0 = 1'b1; bus.wa0 = 5'd9; bus.wd0 = 32'hFFFFFFFF; bus.wbe0 = 4'hF;
        bus.busy_set = 1'b1; bus.busy_addr = 5'd9;
        push("r9_async_rst", 0, 32'h0, 1'b0);
        push("r9_async_rst", 1, 32'h0, 1'b0);
        sample();
        rst = 1'b0;
        idle();
        rdaddr(9, 3);
        push("r9_post_rst", 0, 32'h0, 1'b0);
        push("r3_post_rst", 1, 32'h0, 1'b0);
        sample();

        repeat (2) @(posedge clk);
        if (q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
